// File: rtl/sm4_pkg.sv
// SM4 key-schedule constants and helper functions shared by the key expander and datapath.
// Latency: n/a (package, combinational functions only).
// Backpressure: n/a.
package sm4_pkg;

  localparam int NR = 32;

  localparam logic [31:0] FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] FK1 = 32'h56AA3350;
  localparam logic [31:0] FK2 = 32'h677D9197;
  localparam logic [31:0] FK3 = 32'hB27022DC;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ks_state_t;

  // Whiten the master key into the initial K0..K3 words.
  function automatic logic [127:0] mk_xor_fk(input logic [127:0] mk);
    return mk ^ {FK0, FK1, FK2, FK3};
  endfunction

  // 32-bit rotate left by n (0 < n < 32).
  function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  // Key-schedule linear transform L'(B) = B ^ (B<<<13) ^ (B<<<23).
  function automatic logic [31:0] l_prime(input logic [31:0] b);
    return b ^ rotl32(b, 13) ^ rotl32(b, 23);
  endfunction

  // CK_i: byte j (MSB first) is (4i+j)*7 mod 256.
  function automatic logic [31:0] ck(input logic [4:0] i);
    logic [31:0] r;
    logic [7:0]  base;
    logic [7:0]  v;
    r    = '0;
    base = {1'b0, i, 2'b00};
    for (int j = 0; j < 4; j++) begin
      v = (base + 8'(j)) * 8'd7;
      r[31-8*j -: 8] = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/sm4_sbox.sv
// SM4 8-bit S-box, pure lookup shared with the encryption datapath.
// Latency: combinational, zero cycles.
// Backpressure: none.
module sm4_sbox (
  input  logic [7:0] din_i,
  output logic [7:0] dout_o
);

  // Table stored MSB-first: entry 0 occupies the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  // Entry n sits at bit offset (255-n)*8, and 255-n is simply ~n.
  assign dout_o = SBOX_TBL[{~din_i, 3'b000} +: 8];

endmodule

// File: rtl/sm4_key_expand.sv
// Iterative SM4 key schedule: one round key per cycle into a 32-entry store with a registered read port.
// Latency: done/key_valid 32 cycles after the accepted start edge; rk_out 1 cycle after rk_idx/dec.
// Backpressure: none; start is accepted only in IDLE and ignored while busy.
module sm4_key_expand
  import sm4_pkg::*;
#(
  parameter int NROUNDS = NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  input  logic [4:0]   rk_idx,
  input  logic         dec,
  output logic [31:0]  rk_out
);

  localparam int RW = $clog2(NROUNDS);
  localparam logic [RW-1:0] LAST_ROUND = RW'(NROUNDS - 1);

  ks_state_t       state_q, state_d;
  logic [RW-1:0]   round_q, round_d;
  logic [31:0]     k0_q, k1_q, k2_q, k3_q;
  logic [31:0]     k0_d, k1_d, k2_d, k3_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            kv_q, kv_d;
  logic [31:0]     rk_out_q;
  logic [31:0]     store_q [NROUNDS];

  logic [127:0]    k_init;
  logic [31:0]     sb_in;
  logic [31:0]     sb_out;
  logic [31:0]     rk_new;
  logic [4:0]      rd_idx;

  assign k_init = mk_xor_fk(key);
  assign sb_in  = k1_q ^ k2_q ^ k3_q ^ ck(5'(round_q));

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sm4_sbox u_sbox (
      .din_i  (sb_in[8*g +: 8]),
      .dout_o (sb_out[8*g +: 8])
    );
  end

  assign rk_new = k0_q ^ l_prime(sb_out);

  // Decrypt mode walks the same store from the top down.
  assign rd_idx = dec ? (5'(NROUNDS - 1) - rk_idx) : rk_idx;

  // Next-state logic: key load in IDLE, one round plus K-window shift per cycle in RUN.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    k0_d    = k0_q;
    k1_d    = k1_q;
    k2_d    = k2_q;
    k3_d    = k3_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    kv_d    = kv_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          k0_d    = k_init[127:96];
          k1_d    = k_init[95:64];
          k2_d    = k_init[63:32];
          k3_d    = k_init[31:0];
          round_d = '0;
          busy_d  = 1'b1;
          kv_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        k0_d    = k1_q;
        k1_d    = k2_q;
        k2_d    = k3_q;
        k3_d    = rk_new;
        round_d = round_q + RW'(1);
        if (round_q == LAST_ROUND) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          kv_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control, K window and read-port registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      round_q  <= '0;
      k0_q     <= '0;
      k1_q     <= '0;
      k2_q     <= '0;
      k3_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      kv_q     <= 1'b0;
      rk_out_q <= '0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      k0_q     <= k0_d;
      k1_q     <= k1_d;
      k2_q     <= k2_d;
      k3_q     <= k3_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      kv_q     <= kv_d;
      rk_out_q <= store_q[rd_idx];
    end
  end

  // Round-key store: written once per RUN cycle, deliberately not reset.
  always_ff @(posedge clk) begin
    if (state_q == RUN) begin
      store_q[round_q] <= rk_new;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign key_valid = kv_q;
  assign rk_out    = rk_out_q;

endmodule

// File: tb/tb_sm4_key_expand.sv
module tb_sm4_key_expand;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic         key_valid;
  logic [4:0]   rk_idx;
  logic         dec;
  logic [31:0]  rk_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_rk [32];

  localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;

  logic [2047:0] sbt = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  sm4_key_expand dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key       (key),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid),
    .rk_idx    (rk_idx),
    .dec       (dec),
    .rk_out    (rk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain word-array form of the SM4 key schedule.
  function automatic logic [31:0] m_rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] m_tau(input logic [31:0] x);
    logic [31:0] r;
    int b;
    for (int j = 0; j < 4; j++) begin
      b = int'(x[8*j +: 8]);
      r[8*j +: 8] = sbt[(255 - b) * 8 +: 8];
    end
    return r;
  endfunction

  task automatic ref_model(input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] ckv;
    logic [31:0] b;
    k[0] = mk[127:96] ^ 32'hA3B1BAC6;
    k[1] = mk[95:64]  ^ 32'h56AA3350;
    k[2] = mk[63:32]  ^ 32'h677D9197;
    k[3] = mk[31:0]   ^ 32'hB27022DC;
    for (int i = 0; i < 32; i++) begin
      ckv = 0;
      for (int j = 0; j < 4; j++) ckv = (ckv << 8) | 32'(((4 * i + j) * 7) % 256);
      b = m_tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ckv);
      k[i+4] = k[i] ^ b ^ m_rol(b, 13) ^ m_rol(b, 23);
      exp_rk[i] = k[i+4];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] k);
    key   = k;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 100);
  endtask

  task automatic rd(input int idx, input logic d, output logic [31:0] v);
    rk_idx = 5'(idx);
    dec    = d;
    tick();
    v = rk_out;
  endtask

  task automatic chk_all(input string tag);
    logic [31:0] v;
    for (int i = 0; i < 32; i++) begin
      rd(i, 1'b0, v);
      chk($sformatf("%s_enc%0d", tag, i), v, exp_rk[i]);
    end
    for (int i = 0; i < 32; i++) begin
      rd(i, 1'b1, v);
      chk($sformatf("%s_dec%0d", tag, i), v, exp_rk[31-i]);
    end
  endtask

  initial begin
    int n;
    int npre;
    int dcount;
    logic [31:0] v;
    logic [127:0] rk_key;

    rst_n  = 1'b0;
    start  = 1'b0;
    key    = '0;
    rk_idx = '0;
    dec    = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_kv", 32'(key_valid), 32'd0);
    chk("rst_rkout", rk_out, 32'd0);
    rst_n = 1'b1;
    tick();

    // Standard key, latency and known round keys
    do_start(STD_KEY);
    chk("std_busy", 32'(busy), 32'd1);
    chk("std_kv_low", 32'(key_valid), 32'd0);
    wait_done(n);
    chk("std_latency", 32'(n), 32'd32);
    chk("std_kv", 32'(key_valid), 32'd1);
    chk("std_busy_end", 32'(busy), 32'd0);
    tick();
    chk("std_done_pulse", 32'(done), 32'd0);
    rd(0, 1'b0, v);  chk("std_rk0", v, 32'hF12186F9);
    rd(1, 1'b0, v);  chk("std_rk1", v, 32'h41662B61);
    rd(2, 1'b0, v);  chk("std_rk2", v, 32'h5A6AB19A);
    rd(3, 1'b0, v);  chk("std_rk3", v, 32'h7BA92077);
    rd(31, 1'b0, v); chk("std_rk31", v, 32'h9124A012);

    // Decrypt order and read latency
    rd(0, 1'b1, v);  chk("dec_idx0", v, 32'h9124A012);
    rk_idx = 5'd31;
    dec    = 1'b1;
    #2;
    chk("rd_latency_hold", rk_out, 32'h9124A012);
    tick();
    chk("dec_idx31", rk_out, 32'hF12186F9);

    ref_model(STD_KEY);
    chk_all("std");

    // Start while busy is ignored
    do_start(STD_KEY);
    for (int i = 0; i < 9; i++) tick();
    key   = '1;
    start = 1'b1;
    tick();
    start = 1'b0;
    npre = 10;
    wait_done(n);
    chk("ign_latency", 32'(npre + n), 32'd32);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dcount++;
    end
    chk("ign_no_restart", 32'(dcount), 32'd0);
    chk("ign_busy", 32'(busy), 32'd0);
    rd(0, 1'b0, v);  chk("ign_rk0", v, 32'hF12186F9);
    rd(31, 1'b0, v); chk("ign_rk31", v, 32'h9124A012);
    chk_all("ign");

    // Back-to-back: start with key 0 in the done cycle
    do_start(STD_KEY);
    wait_done(n);
    chk("b2b_first", 32'(n), 32'd32);
    chk("b2b_done_hi", 32'(done), 32'd1);
    do_start(128'h0);
    chk("b2b_kv_fall", 32'(key_valid), 32'd0);
    chk("b2b_done_fall", 32'(done), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(n);
    chk("b2b_second", 32'(n), 32'd32);
    chk("b2b_kv", 32'(key_valid), 32'd1);
    ref_model(128'h0);
    chk_all("zero");

    // Reset in the middle of a run
    rk_key = {$urandom, $urandom, $urandom, $urandom};
    do_start(rk_key);
    for (int i = 0; i < 14; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_kv", 32'(key_valid), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_rkout", rk_out, 32'd0);
    rst_n = 1'b1;
    tick();
    do_start(rk_key);
    wait_done(n);
    chk("mid_latency", 32'(n), 32'd32);
    ref_model(rk_key);
    chk_all("mid");

    // Random keys
    for (int t = 0; t < 200; t++) begin
      rk_key = {$urandom, $urandom, $urandom, $urandom};
      do_start(rk_key);
      wait_done(n);
      chk($sformatf("rnd%0d_latency", t), 32'(n), 32'd32);
      ref_model(rk_key);
      chk_all($sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm4_key_expand.md
Name: sm4_key_expand

Overview:
- Iterative SM4 key schedule. It takes a 128-bit master key MK and produces the 32 round keys rk0..rk31 that feed the SM4 round function, one round key per clock.
- Round keys are held in an internal 32x32 register file behind a registered read port.
- The `dec` input reverses the read index, so the same store serves encryption (rk0 first) and decryption (rk31 first).
- Sits between the key-load interface and the iterative SM4 datapath.

Parameters:
- NROUNDS, 32, number of round keys generated. Fixed by SM4; the parameter exists only for the counter width check.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  load key and begin expansion; sampled only in IDLE
- key  in  128  master key MK, MK0 = key[127:96] ... MK3 = key[31:0]; sampled on the accepted start edge
- busy  out  1  high while expansion runs
- done  out  1  one-cycle pulse when rk31 has been written
- key_valid  out  1  high when the store holds a complete schedule for the last accepted key
- rk_idx  in  5  round-key read index
- dec  in  1  0: read rk[rk_idx]; 1: read rk[31-rk_idx]
- rk_out  out  32  registered read data

Behaviour:
- Clock and reset:
  - One clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset values:
  - state = IDLE, round = 0, busy = 0, done = 0, key_valid = 0, rk_out = 0.
  - K registers are cleared to 0. The rk store is not reset.
- Arithmetic, all mod 2^32:
  - On start: K0..K3 = MKi ^ FKi, with FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
  - Each round i: rk_i = K0 ^ L'(tau(K1^K2^K3^CK_i)).
  - tau applies the SM4 S-box to each byte.
  - L'(B) = B ^ (B<<<13) ^ (B<<<23), where <<< is 32-bit rotate.
  - CK_i byte j = ((4i+j)*7) mod 256, so CK0 = 00070E15, CK1 = 1C232A31, CK31 = 646B7279.
  - After each round: {K0,K1,K2,K3} <= {K1,K2,K3,rk_i}; store[i] <= rk_i.
- State machine (IDLE, RUN):
  - IDLE & start: latch K = MK^FK, round <= 0, busy <= 1, key_valid <= 0, go to RUN.
  - IDLE & !start: hold.
  - RUN: compute one round per edge, round <= round+1.
  - RUN & round == 31: write rk31, go to IDLE, busy <= 0, done <= 1, key_valid <= 1.
  - done is cleared on the next edge.
- Latency:
  - Start sampled at edge E0. rk0..rk31 are written at E1..E32.
  - done and key_valid are visible after E32, which is 32 cycles after the start edge.
- Start handling:
  - start while busy is ignored; the key is not resampled.
  - start in the cycle where done is high is accepted (state is IDLE). key_valid drops after that edge and a new schedule begins.
- Read port:
  - rk_out <= store[dec ? 31-rk_idx : rk_idx] every edge, giving 1-cycle latency.
  - Reads while busy return stale or partial data; consumers gate on key_valid.
- Reset mid-RUN: back to IDLE with reset values. key_valid = 0 and the store contents are undefined.
- The S-box output for every byte value 00..FF is the standard SM4 table; there is no default case reachable.

Decomposition:
- sm4_pkg holds:
  - FK constants
  - CK generation function (or a 32-entry constant array)
  - rotate-left function
  - L' function
  - round-count localparam
- One sub-module, sm4_sbox: an 8-bit combinational S-box shared with the encryption datapath, instantiated 4x.
- The FSM, K shift registers, store and read port stay in sm4_key_expand.

Test Plan:
- Standard key:
  - key = 0123456789ABCDEFFEDCBA9876543210, pulse start.
  - done arrives exactly 32 cycles later.
  - dec = 0 reads rk0 = F12186F9, rk1 = 41662B61, rk2 = 5A6AB19A, rk3 = 7BA92077, rk31 = 9124A012.
- Decrypt order, same key:
  - dec = 1, rk_idx = 0 -> 9124A012; rk_idx = 31 -> F12186F9.
  - rk_out updates one cycle after rk_idx changes.
- Start ignored while busy:
  - Pulse start at cycle 10 of a run with key = all-ones.
  - Still one done pulse, no restart, and the standard-key values above.
- Back-to-back:
  - Assert start with key = 0 in the done cycle.
  - key_valid falls next cycle; a second done comes 32 cycles later.
  - All 32 rk match the C reference model for key 0.
- Reset mid-run:
  - rst_n low at cycle 15 for 1 cycle.
  - busy = 0, key_valid = 0, done = 0, rk_out = 0.
  - A new start then yields correct results.
- Random keys: 200 random keys vs the C reference model, all 32 rk in both dec modes.
